// File: rtl/cortez_cfg_loader_if.sv
// AXI4-Lite write-only channel bundle between the config loader (master) and the CORTEZ regpool (slave).
interface cortez_cfg_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   M_AWADDR;
    logic                    M_AWVALID;
    logic                    M_AWREADY;
    logic [DATA_WIDTH-1:0]   M_WDATA;
    logic [DATA_WIDTH/8-1:0] M_WSTRB;
    logic                    M_WVALID;
    logic                    M_WREADY;
    logic [1:0]              M_BRESP;
    logic                    M_BVALID;
    logic                    M_BREADY;

    modport master (
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID
    );
endinterface

// File: rtl/cortez_cfg_loader.sv
// Hardware sequencer turning a weight/bias/grid byte stream into single-beat AXI4-Lite regpool writes.
// Define CFG_LOADER_AUTOSTART_EN to append the core start-command write after the grid segment.
`ifndef HL_WEIGHTS_0_0_OFFSET
`define HL_WEIGHTS_0_0_OFFSET 32'h0000_0010
`endif
`ifndef HL_BIAS_0_OFFSET
`define HL_BIAS_0_OFFSET 32'h0000_0130
`endif
`ifndef OL_WEIGHTS_0_0_OFFSET
`define OL_WEIGHTS_0_0_OFFSET 32'h0000_0150
`endif
`ifndef OL_BIAS_0_OFFSET
`define OL_BIAS_0_OFFSET 32'h0000_0190
`endif
`ifndef INPUT_GRID_0_OFFSET
`define INPUT_GRID_0_OFFSET 32'h0000_0198
`endif
`ifndef CORE_CTRL_OFFSET
`define CORE_CTRL_OFFSET 32'h0000_0000
`endif

module cortez_cfg_loader #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_INPUTS   = 9,
    parameter int                    NUM_HL_NODES = 8,
    parameter int                    NUM_OL_NODES = 2,
    parameter int                    ADDR_STRIDE  = 4,
    parameter logic [ADDR_WIDTH-1:0] HL_W_BASE    = `HL_WEIGHTS_0_0_OFFSET,
    parameter logic [ADDR_WIDTH-1:0] HL_B_BASE    = `HL_BIAS_0_OFFSET,
    parameter logic [ADDR_WIDTH-1:0] OL_W_BASE    = `OL_WEIGHTS_0_0_OFFSET,
    parameter logic [ADDR_WIDTH-1:0] OL_B_BASE    = `OL_BIAS_0_OFFSET,
    parameter logic [ADDR_WIDTH-1:0] GRID_BASE    = `INPUT_GRID_0_OFFSET,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR    = `CORE_CTRL_OFFSET,
    parameter logic [DATA_WIDTH-1:0] START_CMD    = 8'h02
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [7:0]          S_DATA,
    input  logic                S_VALID,
    output logic                S_READY,
    cortez_cfg_loader_if.master axi,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERROR,
    output logic [15:0]         WRITE_COUNT
);

    localparam int LEN_HL_W = NUM_HL_NODES * NUM_INPUTS;
    localparam int LEN_HL_B = NUM_HL_NODES;
    localparam int LEN_OL_W = NUM_OL_NODES * NUM_HL_NODES;
    localparam int LEN_OL_B = NUM_OL_NODES;
    localparam int LEN_GRID = NUM_INPUTS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_RESP,
        ST_FINISH
    } state_e;

    typedef enum logic [2:0] {
        SEG_HL_W,
        SEG_HL_B,
        SEG_OL_W,
        SEG_OL_B,
        SEG_GRID,
        SEG_CTRL
    } seg_e;

`ifdef CFG_LOADER_AUTOSTART_EN
    localparam seg_e LAST_SEG = SEG_CTRL;
`else
    localparam seg_e LAST_SEG = SEG_GRID;
`endif

    function automatic logic [15:0] seg_len(input seg_e s);
        case (s)
            SEG_HL_W: seg_len = 16'(LEN_HL_W);
            SEG_HL_B: seg_len = 16'(LEN_HL_B);
            SEG_OL_W: seg_len = 16'(LEN_OL_W);
            SEG_OL_B: seg_len = 16'(LEN_OL_B);
            SEG_GRID: seg_len = 16'(LEN_GRID);
            default:  seg_len = 16'd1;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] seg_base(input seg_e s);
        case (s)
            SEG_HL_W: seg_base = HL_W_BASE;
            SEG_HL_B: seg_base = HL_B_BASE;
            SEG_OL_W: seg_base = OL_W_BASE;
            SEG_OL_B: seg_base = OL_B_BASE;
            SEG_GRID: seg_base = GRID_BASE;
            default:  seg_base = CTRL_ADDR;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e                  state;
    state_e                  state_next;
    seg_e                    seg;
    seg_e                    seg_next;
    logic [15:0]             k;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    aw_done;
    logic                    w_done;
    logic [15:0]             write_count_q;
    logic                    error_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    resp_err;
    logic                    last_in_seg;
    logic                    last_elem;
    logic                    ctrl_fetch;

    assign aw_hs       = (state == ST_WRITE) && !aw_done && axi.M_AWREADY;
    assign w_hs        = (state == ST_WRITE) && !w_done && axi.M_WREADY;
    assign resp_err    = (axi.M_BRESP != 2'b00);
    assign last_in_seg = (k == seg_len(seg) - 16'd1);
    assign last_elem   = (seg == LAST_SEG) && last_in_seg;
    assign seg_next    = seg_e'(seg + 3'd1);
    assign ctrl_fetch  = (seg == SEG_CTRL);

    // Address and data hold in registers across WRITE so both channels stay stable under backpressure.
    assign axi.M_AWADDR = addr_q;
    assign axi.M_WDATA  = wdata_q;
    assign axi.M_WSTRB  = '1;
    assign ERROR        = error_q;
    assign WRITE_COUNT  = write_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        S_READY       = 1'b0;
        axi.M_AWVALID = 1'b0;
        axi.M_WVALID  = 1'b0;
        axi.M_BREADY  = 1'b0;
        BUSY          = 1'b1;
        DONE          = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                S_READY = !ctrl_fetch;
                if (ctrl_fetch || S_VALID) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                axi.M_AWVALID = !aw_done;
                axi.M_WVALID  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = ST_RESP;
            end
            ST_RESP: begin
                axi.M_BREADY = 1'b1;
                if (axi.M_BVALID) begin
                    state_next = (resp_err || last_elem) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg           <= SEG_HL_W;
            k             <= 16'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            write_count_q <= 16'd0;
            error_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        seg           <= SEG_HL_W;
                        k             <= 16'd0;
                        addr_q        <= HL_W_BASE;
                        write_count_q <= 16'd0;
                        error_q       <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (ctrl_fetch) begin
                        wdata_q <= START_CMD;
                    end else if (S_VALID) begin
                        wdata_q <= DATA_WIDTH'(S_DATA);
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                ST_RESP: begin
                    if (axi.M_BVALID) begin
                        write_count_q <= sat_inc16(write_count_q);
                        if (resp_err) begin
                            error_q <= 1'b1;
                        end else if (!last_elem) begin
                            if (last_in_seg) begin
                                seg    <= seg_next;
                                k      <= 16'd0;
                                addr_q <= seg_base(seg_next);
                            end else begin
                                k      <= k + 16'd1;
                                addr_q <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
